// File: rtl/csr_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module : csr_writer_pkg
// Brief  : CSR addresses, access opcodes, FSM states and write masks.
// Rev    : 1.0
// ============================================================================
package csr_writer_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] ALIGN4_WMASK  = 32'hFFFF_FFFC;

  // The whole 0xC00-0xFFF quadrant is read-only and owned by the counter block.
  function automatic logic csr_is_ro(input logic [11:0] adr);
    return adr[11:10] == 2'b11;
  endfunction

  function automatic logic csr_is_writable(input logic [11:0] adr);
    case (adr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_wmask(input logic [11:0] adr);
    case (adr)
      CSR_MSTATUS:          return MSTATUS_WMASK;
      CSR_MTVEC, CSR_MEPC:  return ALIGN4_WMASK;
      default:              return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_writer_if.sv
`default_nettype none
// ============================================================================
// Module : csr_writer_if
// Brief  : Core-side START/DONE access handshake of the CSR writer.
// Rev    : 1.0
// ============================================================================
interface csr_writer_if;
  logic        START;
  logic [1:0]  OP;
  logic [11:0] ADR;
  logic [31:0] WDATA;
  logic        WR_EN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RDATA;
  logic        ILLEGAL;

  modport master (
    output START, OP, ADR, WDATA, WR_EN,
    input  BUSY, DONE, RDATA, ILLEGAL
  );

  modport slave (
    input  START, OP, ADR, WDATA, WR_EN,
    output BUSY, DONE, RDATA, ILLEGAL
  );
endinterface
`default_nettype wire

// File: rtl/csr_modify.sv
`default_nettype none
// ============================================================================
// Module : csr_modify
// Brief  : Combinational RW/RS/RC new-value computation with per-CSR mask.
// Rev    : 1.0
// ============================================================================
module csr_modify
  import csr_writer_pkg::*;
(
  input  wire csr_op_e     i_op,
  input  wire logic [11:0] i_adr,
  input  wire logic [31:0] i_old,
  input  wire logic [31:0] i_wdata,
  output logic [31:0]      o_new
);

  logic [31:0] w_raw;

  always_comb begin
    w_raw = i_old;
    case (i_op)
      OP_RW:   w_raw = i_wdata;
      OP_RS:   w_raw = i_old | i_wdata;
      OP_RC:   w_raw = i_old & ~i_wdata;
      default: w_raw = i_old;
    endcase
  end

  assign o_new = w_raw & csr_wmask(i_adr);

endmodule
`default_nettype wire

// File: rtl/csr_writer.sv
`default_nettype none
// ============================================================================
// Module : csr_writer
// Brief  : Zicsr read-modify-write engine for the writable M-mode CSRs.
//          Macro CSR_ILLEGAL_TRAP_EN enables illegal-access detection.
// Rev    : 1.0
// ============================================================================
module csr_writer
  import csr_writer_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  wire logic        CLK,
  input  wire logic        RES,
  csr_writer_if.slave      bus,
  output logic [11:0]      CNT_ADR,
  input  wire logic [31:0] CNT_DATA,
  output logic [31:0]      MTVEC_OUT,
  output logic [31:0]      MEPC_OUT,
  output logic             MIE_OUT
);

  state_e      r_state;
  state_e      w_next;

  csr_op_e     r_op;
  logic [11:0] r_adr;
  logic [31:0] r_wdata;
  logic        r_wr_en;
  logic [31:0] r_rdata;
  logic        r_illegal;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic [31:0] w_local;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_ro;
  logic        w_writable;
  logic        w_wr_attempt;
  logic        w_illegal;
  logic        w_commit;

  always_ff @(posedge CLK) begin
    if (RES) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.START) w_next = ST_READ;
      ST_READ:  w_next = ST_WRITE;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_local = 32'h0;
    case (r_adr)
      CSR_MSTATUS:  w_local = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
      CSR_MTVEC:    w_local = r_mtvec;
      CSR_MSCRATCH: w_local = r_mscratch;
      CSR_MEPC:     w_local = r_mepc;
      CSR_MCAUSE:   w_local = r_mcause;
      CSR_MTVAL:    w_local = r_mtval;
      default:      w_local = 32'h0;
    endcase
  end

  assign w_ro         = csr_is_ro(r_adr);
  assign w_writable   = csr_is_writable(r_adr);
  assign w_old        = w_ro ? CNT_DATA : w_local;
  assign w_wr_attempt = (r_op == OP_RW) || r_wr_en;

`ifdef CSR_ILLEGAL_TRAP_EN
  assign w_illegal = (r_op == OP_RSVD) || (!w_ro && !w_writable) ||
                     (w_ro && w_wr_attempt);
`else
  assign w_illegal = 1'b0;
`endif

  // Read-only and unimplemented targets never commit, so dropped writes
  // in the non-trapping build need no separate path.
  assign w_commit = (r_state == ST_WRITE) && w_writable && !r_illegal &&
                    (r_op != OP_RSVD) && w_wr_attempt;

  csr_modify u_modify (
    .i_op    (r_op),
    .i_adr   (r_adr),
    .i_old   (r_rdata),
    .i_wdata (r_wdata),
    .o_new   (w_new)
  );

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_op       <= OP_RSVD;
      r_adr      <= 12'h0;
      r_wdata    <= 32'h0;
      r_wr_en    <= 1'b0;
      r_rdata    <= 32'h0;
      r_illegal  <= 1'b0;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= MTVEC_RESET & ALIGN4_WMASK;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
      r_mtval    <= 32'h0;
    end else begin
      if (r_state == ST_IDLE && bus.START) begin
        r_op    <= csr_op_e'(bus.OP);
        r_adr   <= bus.ADR;
        r_wdata <= bus.WDATA;
        r_wr_en <= bus.WR_EN;
      end
      if (r_state == ST_READ) begin
        r_rdata   <= w_illegal ? 32'h0 : w_old;
        r_illegal <= w_illegal;
      end
      if (w_commit) begin
        case (r_adr)
          CSR_MSTATUS: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
          end
          CSR_MTVEC:    r_mtvec    <= w_new;
          CSR_MSCRATCH: r_mscratch <= w_new;
          CSR_MEPC:     r_mepc     <= w_new;
          CSR_MCAUSE:   r_mcause   <= w_new;
          CSR_MTVAL:    r_mtval    <= w_new;
          default:      ;
        endcase
      end
    end
  end

  assign bus.BUSY    = (r_state != ST_IDLE);
  assign bus.DONE    = (r_state == ST_RESP);
  assign bus.RDATA   = r_rdata;
  assign bus.ILLEGAL = r_illegal;
  assign CNT_ADR     = r_adr;
  assign MTVEC_OUT   = r_mtvec;
  assign MEPC_OUT    = r_mepc;
  assign MIE_OUT     = r_mie;

endmodule
`default_nettype wire

// File: tb/tb_csr_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_csr_writer
// Brief  : Scoreboard bench for csr_writer; CSR_ILLEGAL_TRAP_EN selects model.
// Rev    : 1.0
// ============================================================================
module tb_csr_writer;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RES;
  logic [11:0] CNT_ADR;
  logic [31:0] CNT_DATA;
  logic [31:0] MTVEC_OUT;
  logic [31:0] MEPC_OUT;
  logic        MIE_OUT;

  int   tb_cyc = 0;
  int   total  = 0;
  int   bad    = 0;
  int   n_done = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  always #5 CLK = ~CLK;
  always @(posedge CLK) tb_cyc <= tb_cyc + 1;

  // Counter block stand-in: value changes every cycle and depends on address.
  function automatic logic [31:0] cnt_f(input int cyc, input logic [11:0] adr);
    logic [31:0] c;
    c = cyc;
    return {c[19:0], adr};
  endfunction

  assign CNT_DATA = cnt_f(tb_cyc, CNT_ADR);

  csr_writer_if u_if ();

  csr_writer #(.MTVEC_RESET(32'h0000_0000)) u_dut (
    .CLK       (CLK),
    .RES       (RES),
    .bus       (u_if),
    .CNT_ADR   (CNT_ADR),
    .CNT_DATA  (CNT_DATA),
    .MTVEC_OUT (MTVEC_OUT),
    .MEPC_OUT  (MEPC_OUT),
    .MIE_OUT   (MIE_OUT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endtask

  always @(negedge CLK) begin
    if (u_if.DONE === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'(u_if.DONE), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rdata", u_if.RDATA, mon_e.rdata);
        check("illegal", 32'(u_if.ILLEGAL), 32'(mon_e.ill));
        check("done_cyc", 32'(tb_cyc), 32'(mon_e.cyc));
        check("mtvec_out", MTVEC_OUT, m_mtvec);
        check("mepc_out", MEPC_OUT, m_mepc);
        check("mie_out", 32'(MIE_OUT), 32'(m_mie));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [11:0] adr,
                       input logic [31:0] wd, input logic wren, input bit push);
    exp_t        e;
    logic [31:0] old, nv;
    logic        ill, ro, wr;
    int          n;
    @(negedge CLK);
    u_if.START = 1'b1;
    u_if.OP    = op;
    u_if.ADR   = adr;
    u_if.WDATA = wd;
    u_if.WR_EN = wren;
    n  = tb_cyc;
    ro = (adr[11:10] == 2'b11);
    wr = 1'b1;
    case (adr)
      12'h300: old = {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
      12'h305: old = m_mtvec;
      12'h340: old = m_mscratch;
      12'h341: old = m_mepc;
      12'h342: old = m_mcause;
      12'h343: old = m_mtval;
      default: begin
        wr  = 1'b0;
        old = ro ? cnt_f(n + 1, adr) : 32'h0;
      end
    endcase
`ifdef CSR_ILLEGAL_TRAP_EN
    ill = (op == 2'b00) || (!ro && !wr) || (ro && (op == 2'b01 || wren));
`else
    ill = 1'b0;
`endif
    e.rdata = ill ? 32'h0 : old;
    e.ill   = ill;
    e.cyc   = n + 3;
    if (push) begin
      sb.push_back(e);
      if (!ill && wr && op != 2'b00 && (op == 2'b01 || wren)) begin
        nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        case (adr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec    = nv & 32'hFFFF_FFFC;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
          default: ;
        endcase
      end
    end
    @(negedge CLK);
    u_if.START = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 12 && n_done < target; i++) begin
      @(posedge CLK);
      #1;
    end
    check("done_count", 32'(n_done), 32'(target));
  endtask

  task automatic access(input logic [1:0] op, input logic [11:0] adr,
                        input logic [31:0] wd, input logic wren);
    int t;
    t = n_done + 1;
    issue(op, adr, wd, wren, 1'b1);
    wait_done(t);
  endtask

  initial begin
    exp_t e;
    int   n, t;
    RES = 1'b1;
    u_if.START = 1'b0; u_if.OP = 2'b00; u_if.ADR = 12'h0;
    u_if.WDATA = 32'h0; u_if.WR_EN = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(u_if.BUSY), 32'd0);
    check("rst_done", 32'(u_if.DONE), 32'd0);
    check("rst_rdata", u_if.RDATA, 32'd0);
    check("rst_illegal", 32'(u_if.ILLEGAL), 32'd0);
    check("rst_cnt_adr", 32'(CNT_ADR), 32'd0);
    check("rst_mtvec", MTVEC_OUT, 32'd0);
    check("rst_mepc", MEPC_OUT, 32'd0);
    check("rst_mie", 32'(MIE_OUT), 32'd0);
    RES = 1'b0;

    access(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b1);
    access(2'b10, 12'h340, 32'h0, 1'b0);

    access(2'b10, 12'h300, 32'hFFFF_FFFF, 1'b1);
    access(2'b10, 12'h300, 32'h0, 1'b0);
    access(2'b11, 12'h300, 32'h8, 1'b1);
    access(2'b10, 12'h300, 32'h0, 1'b0);

    access(2'b01, 12'h305, 32'h8000_0003, 1'b1);
    access(2'b01, 12'h341, 32'h0000_1003, 1'b1);
    access(2'b01, 12'h342, 32'h8000_000B, 1'b1);
    access(2'b10, 12'h343, 32'h0000_00F0, 1'b1);
    access(2'b11, 12'h343, 32'h0000_0030, 1'b1);
    access(2'b10, 12'h343, 32'h0, 1'b0);

    access(2'b01, 12'hC00, 32'h5, 1'b1);
    access(2'b10, 12'hC00, 32'h0, 1'b0);
    access(2'b11, 12'hF14, 32'h0, 1'b0);
    access(2'b00, 12'h340, 32'h1234, 1'b1);
    access(2'b01, 12'h7C0, 32'hFFFF_FFFF, 1'b1);
    access(2'b10, 12'h340, 32'h0, 1'b0);

    // Reset lands on the WRITE cycle of an mepc update.
    issue(2'b01, 12'h341, 32'h0000_1000, 1'b1, 1'b0);
    @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    RES = 1'b0;
    model_reset();
    check("abort_mepc", MEPC_OUT, 32'd0);
    check("abort_mtvec", MTVEC_OUT, 32'd0);
    check("abort_busy", 32'(u_if.BUSY), 32'd0);
    access(2'b01, 12'h340, 32'h1234_5678, 1'b1);
    access(2'b10, 12'h340, 32'h0, 1'b0);

    // START held high: one acceptance per 4 cycles, DONE-cycle START ignored.
    t = n_done + 3;
    @(negedge CLK);
    u_if.START = 1'b1; u_if.OP = 2'b10; u_if.ADR = 12'h340;
    u_if.WDATA = 32'h0; u_if.WR_EN = 1'b0;
    n = tb_cyc;
    for (int k = 0; k < 3; k++) begin
      e.rdata = m_mscratch;
      e.ill   = 1'b0;
      e.cyc   = n + 3 + 4 * k;
      sb.push_back(e);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      check("busy_hold", 32'(u_if.BUSY), 32'((i % 4) != 0));
    end
    u_if.START = 1'b0;
    repeat (4) @(negedge CLK);
    check("hold_done_count", 32'(n_done), 32'(t));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
